// File: rtl/rr_onehot_sel_arb3.sv
// rr_onehot_sel_arb3: 3-source round-robin arbiter with max-hold. clk/rst_n (sync, active-low) in; req[2:0] in; sel (one-hot or zero), sel_valid, sel_idx out, all registered.
module rr_onehot_sel_arb3 #(
  parameter int MAX_HOLD = 4,
  localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic [1:0] sel_idx
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] last_ptr, s1, s2, s3, win;
  logic [CNT_W-1:0] hold_cnt;
  logic expired, keep, found;
  logic [2:0] cand;
  function automatic logic [1:0] nxt(input logic [1:0] p);
    return p == 2'd2 ? 2'd0 : p + 2'd1;
  endfunction
  always_comb begin
    expired = hold_cnt == CNT_W'(MAX_HOLD);
    keep = state == GRANT && req[sel_idx] && (!expired || (req & ~sel) == 3'b000);
    cand = state == GRANT ? req & ~sel : req;
    s1 = nxt(last_ptr);
    s2 = nxt(s1);
    s3 = nxt(s2);
    win = cand[s1] ? s1 : cand[s2] ? s2 : s3;
    found = |cand;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= 3'b000;
      sel_valid <= 1'b0;
      sel_idx <= 2'd0;
      last_ptr <= 2'd2;
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= expired ? hold_cnt : hold_cnt + CNT_W'(1);
    end else if (found) begin
      state <= GRANT;
      sel <= 3'b001 << win;
      sel_valid <= 1'b1;
      sel_idx <= win;
      last_ptr <= win;
      hold_cnt <= CNT_W'(1);
    end else begin
      state <= IDLE;
      sel <= 3'b000;
      sel_valid <= 1'b0;
      sel_idx <= 2'd0;
      hold_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_rr_onehot_sel_arb3.sv
// tb_rr_onehot_sel_arb3: directed and random checks of the arbiter against a queue-free behavioural model.
module tb_rr_onehot_sel_arb3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] sel [2];
  logic sel_valid [2];
  logic [1:0] sel_idx [2];
  int errs = 0;
  int checks = 0;
  int holder [2];
  int cnt [2];
  int last [2];
  int maxh [2] = '{4, 1};
  always #5 clk = ~clk;
  rr_onehot_sel_arb3 #(.MAX_HOLD(4)) dut0 (.clk(clk), .rst_n(rst_n), .req(req), .sel(sel[0]), .sel_valid(sel_valid[0]), .sel_idx(sel_idx[0]));
  rr_onehot_sel_arb3 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .req(req), .sel(sel[1]), .sel_valid(sel_valid[1]), .sel_idx(sel_idx[1]));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input int m, input logic [2:0] r, input logic rn);
    logic [2:0] c;
    if (!rn) begin
      holder[m] = -1;
      cnt[m] = 0;
      last[m] = 2;
      return;
    end
    c = r;
    if (holder[m] >= 0) c[holder[m]] = 1'b0;
    if (holder[m] >= 0 && r[holder[m]] && (cnt[m] < maxh[m] || c == 3'b000)) begin
      if (cnt[m] < maxh[m]) cnt[m]++;
      return;
    end
    holder[m] = -1;
    cnt[m] = 0;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last[m] + k) % 3;
      if (c[i] && holder[m] < 0) begin
        holder[m] = i;
        last[m] = i;
        cnt[m] = 1;
      end
    end
  endtask
  task automatic step(input logic [2:0] r, input logic rn);
    req = r;
    rst_n = rn;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model(m, r, rn);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "sel_h4" : "sel_h1", sel[m], holder[m] < 0 ? 0 : 1 << holder[m]);
      chk(m == 0 ? "valid_h4" : "valid_h1", sel_valid[m], holder[m] >= 0);
      chk(m == 0 ? "idx_h4" : "idx_h1", sel_idx[m], holder[m] < 0 ? 0 : holder[m]);
      chk("onehot0", $onehot0(sel[m]), 1);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) step(3'b111, 1'b0);
    chk("reset_sel", sel[0], 0);
    for (int i = 0; i < 13; i++) begin
      step(3'b111, 1'b1);
      chk("rot_sel", sel[0], i < 4 ? 1 : i < 8 ? 2 : i < 12 ? 4 : 1);
    end
    step(3'b000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(3'b010, 1'b1);
      chk("solo_sel", sel[0], 2);
    end
    step(3'b011, 1'b1);
    chk("sat_rotate", sel[0], 1);
    step(3'b100, 1'b1);
    chk("no_bubble", sel[0], 4);
    step(3'b000, 1'b1);
    chk("drop_idle", sel_valid[0], 0);
    step(3'b101, 1'b1);
    chk("wrap", sel[0], 1);
    step(3'b000, 1'b1);
    for (int i = 0; i < 3; i++) step(3'b010, 1'b1);
    chk("mid_grant", sel[0], 2);
    step(3'b010, 1'b0);
    chk("mid_reset", sel[0], 0);
    step(3'b110, 1'b1);
    chk("restart", sel[0], 2);
    for (int i = 0; i < 3000; i++) step(3'($urandom), $urandom_range(0, 59) != 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
